// File: rtl/pipe_pkg.sv
// Shared types and per-boundary widths for the pipeline stage registers.
// Pure declarations: no logic, no latency, no flow control.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam int PIPE_IDEX_DATA_W = 96;
  localparam int PIPE_IDEX_CTRL_W = 16;

  localparam logic [PIPE_IDEX_CTRL_W-1:0] PIPE_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+data+ctrl holding register; clear beats load and forces the control to the bubble value.
// Latency 1 cycle from load to outputs; no flow control of its own, the owner decides load/clear.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = PIPE_IDEX_DATA_W,
  parameter int                CTRL_W      = PIPE_IDEX_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter logic [DATA_W-1:0] DATA_RST    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Data is left alone on clear so the output bus does not toggle on bubbles.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= DATA_RST;
      ctrl_q  <= CTRL_BUBBLE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register, 1-cycle latency, flush inserts a bubble; PIPE_SKID_EN adds a skid entry
// so in_ready is registered (~skid valid), otherwise in_ready = ~out_valid | out_ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = PIPE_IDEX_DATA_W,
  parameter int                CTRL_W      = PIPE_IDEX_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_NOP),
  parameter logic [DATA_W-1:0] DATA_RST    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  pipe_state_e       state;
  logic              rdy_q;
  logic              accept, retire;
  logic              h_vld, h_load, h_clear;
  logic [DATA_W-1:0] h_dat, h_din;
  logic [CTRL_W-1:0] h_ctl, h_cin;
  logic              s_vld;
  logic [DATA_W-1:0] s_dat;
  logic [CTRL_W-1:0] s_ctl;

  // Keeps in_ready low for the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!rst) rdy_q <= 1'b0;
    else      rdy_q <= 1'b1;
  end

  assign state  = s_vld ? SKID : (h_vld ? FULL : EMPTY);
  assign accept = in_valid & in_ready;
  assign retire = h_vld & out_ready;

  always_comb begin
    h_load  = 1'b0;
    h_clear = flush;
    h_din   = in_data;
    h_cin   = in_ctrl;
    case (state)
      EMPTY: h_load = accept;
      FULL: begin
        h_load  = accept & retire;
        h_clear = flush | (retire & ~accept);
      end
      SKID: begin
        h_load = retire;
        h_din  = s_dat;
        h_cin  = s_ctl;
      end
      default: h_load = 1'b0;
    endcase
  end

  pipe_skid_entry #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE), .DATA_RST(DATA_RST)
  ) u_head (
    .clk(clk), .rst(rst), .load_i(h_load), .clear_i(h_clear),
    .data_i(h_din), .ctrl_i(h_cin),
    .valid_o(h_vld), .data_o(h_dat), .ctrl_o(h_ctl)
  );

`ifdef PIPE_SKID_EN
  logic s_load, s_clear;

  // A beat lands in the skid entry only when the head is held and not draining.
  assign s_load  = (state == FULL) & accept & ~retire;
  assign s_clear = flush | retire;

  pipe_skid_entry #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE), .DATA_RST(DATA_RST)
  ) u_skid (
    .clk(clk), .rst(rst), .load_i(s_load), .clear_i(s_clear),
    .data_i(in_data), .ctrl_i(in_ctrl),
    .valid_o(s_vld), .data_o(s_dat), .ctrl_o(s_ctl)
  );

  assign in_ready = rst & rdy_q & ~s_vld;
`else
  assign s_vld    = 1'b0;
  assign s_dat    = DATA_RST;
  assign s_ctl    = CTRL_BUBBLE;
  assign in_ready = rst & rdy_q & (~h_vld | out_ready);
`endif

  assign out_valid = h_vld;
  assign out_data  = h_dat;
  assign out_ctrl  = h_ctl;
  assign occupancy = 2'(h_vld) + 2'(s_vld);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic, all checked against a FIFO-queue model.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [15:0] BUBBLE = 16'h0000;

  typedef struct {
    logic [95:0] d;
    logic [15:0] c;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [15:0] in_ctrl;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;

  pipe_stage_reg #(
    .DATA_W(96), .CTRL_W(16), .CTRL_BUBBLE(16'h0000), .DATA_RST(96'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  beat_t       q[$];
  beat_t       src[$];
  beat_t       pend;
  bit          pend_vld = 0;
  logic [95:0] last_d = '0;
  bit          rdy_ok = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_rdy();
    if (!rst || !rdy_ok) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic logic [95:0] exp_data();
    return (q.size() > 0) ? q[0].d : last_d;
  endfunction

  function automatic logic [15:0] exp_ctrl();
    return (q.size() > 0) ? q[0].c : BUBBLE;
  endfunction

  function automatic beat_t mk(input logic [95:0] d, input logic [15:0] c);
    beat_t b;
    b.d = d;
    b.c = c;
    return b;
  endfunction

  // One cycle: drive from the source queue, check outputs, advance the model at the edge.
  task automatic step();
    bit e_rdy, acc, ret;
    if (!pend_vld && src.size() > 0) begin
      pend     = src.pop_front();
      pend_vld = 1;
    end
    in_valid = pend_vld;
    in_data  = pend.d;
    in_ctrl  = pend.c;
    #1;
    e_rdy = exp_rdy();
    chk("in_ready",  128'(in_ready),  128'(e_rdy));
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("out_data",  128'(out_data),  128'(exp_data()));
    chk("out_ctrl",  128'(out_ctrl),  128'(exp_ctrl()));
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    acc = in_valid && e_rdy;
    ret = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      last_d = '0;
      rdy_ok = 0;
    end else begin
      rdy_ok = 1;
      if (flush) begin
        if (q.size() > 0) last_d = q[0].d;
        q.delete();
      end else begin
        if (ret) begin
          last_d = q[0].d;
          void'(q.pop_front());
        end
        if (acc) q.push_back(mk(in_data, in_ctrl));
      end
    end
    if (acc || flush || !rst) pend_vld = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
    pend = mk('0, '0);
    @(posedge clk);
    @(negedge clk);

    // Reset held 3 cycles with traffic offered.
    for (int k = 0; k < 3; k++) src.push_back(mk(96'(32'hEE00 + k), 16'h00EE));
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rel_in_ready", 128'(in_ready), 128'(1));

    // Back-to-back streaming of 1..8.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) src.push_back(mk(96'(k), 16'(k)));
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("stream_vld",  128'(out_valid), 128'(1));
      chk("stream_data", 128'(out_data),  128'(k));
    end
    repeat (2) step();

    // Stall with A, B, C offered.
    out_ready = 1'b0;
    src.push_back(mk(96'hA, 16'h000A));
    src.push_back(mk(96'hB, 16'h000B));
    src.push_back(mk(96'hC, 16'h000C));
    repeat (4) step();
    chk("stall_occ",      128'(occupancy), 128'(CAP));
    chk("stall_in_ready", 128'(in_ready),  128'(0));
    chk("stall_head",     128'(out_data),  128'(96'hA));
    out_ready = 1'b1;
    repeat (6) step();
    chk("stall_drained", 128'(out_valid), 128'(0));
    chk("stall_last",    128'(out_data),  128'(96'hC));

    // Flush while full with 0xD offered.
    out_ready = 1'b0;
    src.push_back(mk(96'h1111, 16'h0011));
    src.push_back(mk(96'h2222, 16'h0022));
    repeat (2) step();
    src.push_back(mk(96'hD, 16'h000D));
    flush = 1'b1;
    step();
    flush = 1'b0;
    src.delete();
    chk("flush_occ",  128'(occupancy), 128'(0));
    chk("flush_vld",  128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl),  128'(BUBBLE));
    out_ready = 1'b1;
    repeat (4) step();

    // Retire and accept in the same cycle.
    src.push_back(mk(96'hE, 16'h000E));
    step();
    src.push_back(mk(96'hF, 16'h000F));
    step();
    chk("simul_occ",  128'(occupancy), 128'(1));
    chk("simul_vld",  128'(out_valid), 128'(1));
    chk("simul_data", 128'(out_data),  128'(96'hF));
    step();

    // Reset mid-stream while holding beats.
    out_ready = 1'b0;
    src.push_back(mk(96'h6, 16'h0066));
    src.push_back(mk(96'h7, 16'h0077));
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("mrst_vld",  128'(out_valid), 128'(0));
    chk("mrst_occ",  128'(occupancy), 128'(0));
    chk("mrst_data", 128'(out_data),  128'(0));
    chk("mrst_ctrl", 128'(out_ctrl),  128'(BUBBLE));
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mrst_no_stale", 128'(out_valid), 128'(0));
    end

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if (src.size() == 0 && $urandom_range(0, 9) < 6)
        src.push_back(mk({$urandom(), $urandom(), $urandom()}, 16'($urandom())));
      step();
    end
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
